// File: rtl/wallace_seq_ctrl_pkg.sv
// Shared types and constants for the time-shared Wallace multiplier controller.
package wallace_pkg;

   localparam int OPER_W = 16;
   localparam int COMP_W = 32;
   localparam int STEPS  = OPER_W / 2;

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      ADD,
      DONE
   } state_t;

endpackage

// File: rtl/wallace_seq_ctrl_if.sv
// Operand/result handshake bundle between producer, controller and consumer.
interface wallace_seq_ctrl_if
   import wallace_pkg::*;
#(
   parameter int WIDTH  = OPER_W,
   parameter int ITER_W = 4
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic [ITER_W-1:0]    iter;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy, iter
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy, iter
   );

endinterface

// File: rtl/Compressor_42.sv
// Bitwise 4:2 compressor built from two full-adder layers; cout never depends on cin.
module Compressor_42 #(
   parameter int W = 32
) (
   input  logic [W-1:0] x [4],
   input  logic [W-1:0] cin,
   output logic [W-1:0] s,
   output logic [W-1:0] c,
   output logic [W-1:0] cout
);

   logic [W-1:0] t;

   assign t    = x[0] ^ x[1] ^ x[2];
   assign cout = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
   assign s    = t ^ x[3] ^ cin;
   assign c    = (t & x[3]) | (t & cin) | (x[3] & cin);

endmodule

// File: rtl/wallace_seq_ctrl.sv
// Iterative multiplier controller folding two partial-product rows per cycle into a carry-save pair.
// Optional early termination on exhausted multiplier bits: define WALLACE_EARLY_EXIT_EN.
module wallace_seq_ctrl
   import wallace_pkg::*;
#(
   parameter int WIDTH  = OPER_W,
   parameter int ITER_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   wallace_seq_ctrl_if.slave bus
);

   localparam int N_STEPS = WIDTH / 2;
   localparam int IDX_W   = ITER_W + 1;

   state_t             state, state_nxt, start_state;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [COMP_W-1:0]  s_q, c_q, product_q;
   logic [ITER_W-1:0]  iter_q;
   logic               out_valid_q;
   logic               in_ready, accept, last_step;
   logic [IDX_W-1:0]   even_idx, odd_idx;
   logic [WIDTH-1:0]   b_even_sh, b_odd_sh;
   logic [COMP_W-1:0]  pp_even, pp_odd;
   logic [COMP_W-1:0]  comp_x [4];
   logic [COMP_W-1:0]  comp_cin, comp_s, comp_c, comp_cout;
   logic               cout_msb_unused;

   assign in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // Rows 2k and 2k+1 of the partial-product array for the current step k.
   assign even_idx  = {iter_q, 1'b0};
   assign odd_idx   = {iter_q, 1'b1};
   assign b_even_sh = b_q >> even_idx;
   assign b_odd_sh  = b_q >> odd_idx;
   assign pp_even   = b_even_sh[0] ? (COMP_W'(a_q) << even_idx) : '0;
   assign pp_odd    = b_odd_sh[0]  ? (COMP_W'(a_q) << odd_idx)  : '0;

   // Carry-outs feed the next bit's cin; the top carry falls off the 32-bit result.
   assign comp_x[0]       = s_q;
   assign comp_x[1]       = c_q << 1;
   assign comp_x[2]       = pp_even;
   assign comp_x[3]       = pp_odd;
   assign comp_cin        = {comp_cout[COMP_W-2:0], 1'b0};
   assign cout_msb_unused = comp_cout[COMP_W-1];

   Compressor_42 #(.W(COMP_W)) u_comp (
      .x    (comp_x),
      .cin  (comp_cin),
      .s    (comp_s),
      .c    (comp_c),
      .cout (comp_cout)
   );

`ifdef WALLACE_EARLY_EXIT_EN
   logic [IDX_W-1:0] rest_idx;
   logic [WIDTH-1:0] b_rest_sh;

   assign rest_idx    = even_idx + IDX_W'(2);
   assign b_rest_sh   = b_q >> rest_idx;
   assign last_step   = (iter_q == ITER_W'(N_STEPS - 1)) || (b_rest_sh == '0);
   assign start_state = (bus.b == '0) ? ADD : REDUCE;
`else
   assign last_step   = (iter_q == ITER_W'(N_STEPS - 1));
   assign start_state = REDUCE;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign bus.busy      = (state == REDUCE) || (state == ADD);
   assign bus.iter      = iter_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = start_state;
         REDUCE:  if (last_step) state_nxt = ADD;
         ADD:     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = accept ? start_state : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A new accept always restarts the carry-save pair, even straight out of DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         c_q         <= '0;
         iter_q      <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            s_q    <= '0;
            c_q    <= '0;
            iter_q <= '0;
         end else if (state == REDUCE) begin
            s_q    <= comp_s;
            c_q    <= comp_c;
            iter_q <= iter_q + ITER_W'(1);
         end

         if (state == ADD) begin
            product_q   <= s_q + (c_q << 1);
            out_valid_q <= 1'b1;
         end else if (state == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wallace_seq_ctrl.sv
// Scoreboard bench for wallace_seq_ctrl: directed latency/handshake/reset cases plus a random sweep.
module tb_wallace_seq_ctrl;
   import wallace_pkg::*;

`ifdef WALLACE_EARLY_EXIT_EN
   localparam int LAT_3X5  = 3;
   localparam int LAT_7X9  = 3;
   localparam int ITER_3X5 = 2;
`else
   localparam int LAT_3X5  = 9;
   localparam int LAT_7X9  = 9;
   localparam int ITER_3X5 = 8;
`endif

   logic        clk;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   bit          rand_mode = 0;
   logic [31:0] sb_q [$];

   wallace_seq_ctrl_if bus_if ();

   wallace_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands, wait for acceptance and record the expected product.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      bit taken = 0;
      bus_if.a        = a;
      bus_if.b        = b;
      bus_if.in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus_if.in_ready) begin
            taken = 1;
            break;
         end
      end
      if (!taken) checkOutput("accept_timeout", 0, 1);
      else sb_q.push_back(32'(a) * 32'(b));
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic waitOutput(output int cycles);
      cycles = 0;
      while (!bus_if.out_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic waitDrain(input string tag);
      for (int n = 0; n < 400 && sb_q.size() != 0; n++) @(posedge clk);
      #1;
      checkOutput(tag, 64'(sb_q.size()), 0);
   endtask

   // Every product handshake is compared against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
         if (sb_q.size() == 0) checkOutput("spurious_output", 1, 0);
         else checkOutput("product", bus_if.product, sb_q.pop_front());
      end
   end

   // Random consumer back-pressure during the sweep.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) bus_if.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int cycles;
      int busy_cnt;
      int valid_cnt;
      logic [15:0] ra, rb;

      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.out_ready = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_in_ready", bus_if.in_ready, 1);
      checkOutput("rst_out_valid", bus_if.out_valid, 0);
      checkOutput("rst_busy", bus_if.busy, 0);
      checkOutput("rst_product", bus_if.product, 0);
      checkOutput("rst_iter", bus_if.iter, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // 3 x 5: latency and busy window
      applyStimulus(16'h0003, 16'h0005);
      checkOutput("busy_in_ready", bus_if.in_ready, 0);
      cycles = 0;
      busy_cnt = 0;
      while (!bus_if.out_valid && cycles < 40) begin
         if (bus_if.busy) busy_cnt++;
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("latency_3x5", cycles, LAT_3X5);
      checkOutput("busy_cycles", busy_cnt, LAT_3X5);
      checkOutput("busy_in_done", bus_if.busy, 0);
      checkOutput("iter_3x5", bus_if.iter, ITER_3X5);
      checkOutput("product_3x5", bus_if.product, 32'h0000_000F);
      waitDrain("drain_3x5");

      // full carry propagation
      applyStimulus(16'hFFFF, 16'hFFFF);
      waitOutput(cycles);
      checkOutput("product_ffff", bus_if.product, 32'hFFFE_0001);
      waitDrain("drain_ffff");

      // back-pressure then same-edge accept out of DONE
      bus_if.out_ready = 1'b0;
      applyStimulus(16'h1234, 16'h5678);
      waitOutput(cycles);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_valid", bus_if.out_valid, 1);
         checkOutput("hold_product", bus_if.product, 32'h0626_0060);
         @(posedge clk);
         #1;
      end
      bus_if.out_ready = 1'b1;
      applyStimulus(16'h0007, 16'h0009);
      checkOutput("b2b_valid_drop", bus_if.out_valid, 0);
      checkOutput("b2b_busy", bus_if.busy, 1);
      waitOutput(cycles);
      checkOutput("latency_7x9", cycles, LAT_7X9);
      checkOutput("product_7x9", bus_if.product, 32'h0000_003F);
      waitDrain("drain_b2b");

      // asynchronous reset in the middle of a reduction
      applyStimulus(16'hABCD, 16'h1234);
      for (int n = 0; n < 20 && bus_if.iter != 4'd4; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("mid_iter", bus_if.iter, 4);
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      checkOutput("mid_rst_busy", bus_if.busy, 0);
      checkOutput("mid_rst_in_ready", bus_if.in_ready, 1);
      checkOutput("mid_rst_iter", bus_if.iter, 0);
      checkOutput("mid_rst_product", bus_if.product, 0);
      checkOutput("mid_rst_valid", bus_if.out_valid, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      valid_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (bus_if.out_valid) valid_cnt++;
      end
      checkOutput("no_partial_result", valid_cnt, 0);
      applyStimulus(16'h0002, 16'h0003);
      waitOutput(cycles);
      checkOutput("product_2x3", bus_if.product, 32'h0000_0006);
      waitDrain("drain_rst");

`ifdef WALLACE_EARLY_EXIT_EN
      applyStimulus(16'h1111, 16'h0003);
      waitOutput(cycles);
      checkOutput("ee_latency_b3", cycles, 2);
      checkOutput("ee_iter_b3", bus_if.iter, 1);
      checkOutput("ee_product_b3", bus_if.product, 32'h0000_3333);
      waitDrain("drain_ee_b3");
      applyStimulus(16'h5A5A, 16'h0000);
      waitOutput(cycles);
      checkOutput("ee_latency_b0", cycles, 1);
      checkOutput("ee_product_b0", bus_if.product, 0);
      waitDrain("drain_ee_b0");
`endif

      // random sweep with throttled consumer
      rand_mode = 1;
      for (int i = 0; i < 1000; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus(ra, rb);
      end
      rand_mode = 0;
      @(posedge clk);
      #2;
      bus_if.out_ready = 1'b1;
      waitDrain("drain_random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
